eight_bit_down_counter_timer: RTL and testbench
===============================================

Name: eight_bit_down_counter_timer

Overview:
- Loadable 8-bit down-counter/timer with a start/pause handshake and a terminal-count pulse.
- Counterpart to the team's free-running up-counter: the up-counter measures elapsed cycles; this block counts a programmed value down to zero and signals expiry.
- Used as the datapath delay/timeout element in the lab processor and its peripherals.

Parameters:
WIDTH, 8, counter and load-value width in bits.

Ports:
Clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low; rst=0 clears all state immediately
load  input  1  load request; samples load_val
load_val  input  WIDTH  value to load into counter and reload register
start  input  1  start/restart request
pause  input  1  hold count while in RUN
out  output  WIDTH  current count (registered)
busy  output  1  high while state is RUN
tc  output  1  one-cycle terminal-count pulse, high in the cycle out first shows 0
done  output  1  high while state is DONE

Behaviour:
- All outputs registered. States: IDLE, RUN, DONE (2-bit encoding, unused code returns to IDLE).
- Reset (rst=0, asynchronous): out=0, reload_reg=0, state=IDLE, busy=0, tc=0, done=0. Deasserting rst is synchronous to Clk; first update on the next rising edge.
- Internal reload_reg captures load_val on every accepted load.
- tc defaults to 0 every cycle unless set by a rule below.
- IDLE:
  - load=1: out<=load_val, reload_reg<=load_val.
  - load=1 and start=1 together: the load is taken. Next state is RUN if load_val!=0. If load_val==0, next state is DONE and tc=1.
  - start=1 alone: out!=0 goes to RUN. out==0 goes to DONE with tc=1.
  - pause is ignored.
- RUN:
  - No decrement on the edge that enters RUN; the first decrement is on the following edge.
  - Each edge with pause=0: out<=out-1.
  - When out==1 and pause=0: out<=0, tc<=1, next state DONE.
  - pause=1: out holds and tc stays 0.
  - load=1 has priority over decrement and pause: out<=load_val and reload_reg<=load_val. State stays RUN, or goes to DONE with tc=1 if load_val==0.
  - start is ignored.
- DONE:
  - done=1, out=0.
  - start=1: out<=reload_reg, next state RUN. If reload_reg==0, stay DONE and pulse tc again.
  - load=1: out<=load_val, reload_reg<=load_val, next state IDLE.
  - load and start together: load wins, then the IDLE load+start rule applies.
- Latency: start accepted at edge N with out=V (V>0) gives tc=1 and out=0 after edge N+V.
- No wrap-around: out never decrements below 0.
- Reset mid-count aborts immediately to the reset values. A pending tc is lost.

Optional Feature:
AUTO_RELOAD_EN
- Defined: in RUN, the edge where out reaches 0 still pulses tc but the state stays RUN. On the next unpaused edge, out<=reload_reg, giving a period of reload_reg+1 cycles. If reload_reg==0, enter DONE as normal. done asserts only through that path or via load of 0.
- Undefined: single-shot behaviour as described in Behaviour; RUN always exits to DONE at terminal count.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-count (out=5) -> out=0, busy=0, tc=0, done=0 immediately, without waiting for a clock edge.
- Basic count: load 3, then start -> out sequence 3,2,1,0. tc=1 only in the cycle out=0, exactly 3 edges after the start edge. done=1 afterwards.
- Pause: load 4, start, pause high for 2 cycles after the first decrement -> out holds at 3 for 2 cycles. tc fires 2 cycles later than in the unpaused run.
- Boundary and collision cases:
  - Load 0 with start -> DONE next edge with tc pulse.
  - Load in RUN at out=2 with load_val=6 -> out=6 next edge, then counts down from 6.
  - load and start in the same cycle with load_val=2 -> out 2,1,0.
- Restart from DONE: after counting down from 5, assert start -> out=5, then counts to 0 with a second tc. Load 9 in DONE -> IDLE with out=9.
- AUTO_RELOAD_EN defined: load 2, start -> out 2,1,0,2,1,0... with tc every 3 cycles and done never set. pause freezes the sequence.

Source files
------------

// File: rtl/eight_bit_down_counter_timer.sv
// Loadable down-counter/timer with start/pause handshake and terminal-count pulse.
// Build option: define AUTO_RELOAD_EN for periodic reload instead of single-shot expiry.
module eight_bit_down_counter_timer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    // state  | meaning
    // S_IDLE | loaded or reset, waiting for start
    // S_RUN  | counting down one per unpaused edge
    // S_DONE | expired, out held at 0, start reloads from reload_reg
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state, state_nx;
    logic [WIDTH-1:0] reload_reg, reload_nx, out_nx;
    logic             tc_nx, busy_nx, done_nx;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            out        <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            out        <= out_nx;
            reload_reg <= reload_nx;
            tc         <= tc_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        out_nx    = out;
        reload_nx = reload_reg;
        tc_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    out_nx    = load_val;
                    reload_nx = load_val;
                    if (start) begin
                        if (load_val != ZERO) begin
                            state_nx = S_RUN;
                        end else begin
                            state_nx = S_DONE;
                            tc_nx    = 1'b1;
                        end
                    end
                end else if (start) begin
                    if (out != ZERO) begin
                        state_nx = S_RUN;
                    end else begin
                        state_nx = S_DONE;
                        tc_nx    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (load) begin
                    out_nx    = load_val;
                    reload_nx = load_val;
                    if (load_val == ZERO) begin
                        state_nx = S_DONE;
                        tc_nx    = 1'b1;
                    end
                end else if (!pause) begin
                    if (out == ZERO) begin
`ifdef AUTO_RELOAD_EN
                        // count already expired last edge; restart the period
                        if (reload_reg == ZERO) begin
                            state_nx = S_DONE;
                        end else begin
                            out_nx = reload_reg;
                        end
`else
                        state_nx = S_DONE;
`endif
                    end else if (out == ONE) begin
                        out_nx = ZERO;
                        tc_nx  = 1'b1;
`ifndef AUTO_RELOAD_EN
                        state_nx = S_DONE;
`endif
                    end else begin
                        out_nx = out - ONE;
                    end
                end
            end
            S_DONE: begin
                if (load) begin
                    out_nx    = load_val;
                    reload_nx = load_val;
                    state_nx  = S_IDLE;
                    if (start) begin
                        if (load_val != ZERO) begin
                            state_nx = S_RUN;
                        end else begin
                            state_nx = S_DONE;
                            tc_nx    = 1'b1;
                        end
                    end
                end else if (start) begin
                    if (reload_reg != ZERO) begin
                        out_nx   = reload_reg;
                        state_nx = S_RUN;
                    end else begin
                        tc_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_nx = (state_nx == S_RUN);
        done_nx = (state_nx == S_DONE);
    end

endmodule

// File: tb/tb_eight_bit_down_counter_timer.sv
// Self-checking bench for eight_bit_down_counter_timer: directed scenarios plus a
// randomized run scored against a behavioural timer model.
module tb_eight_bit_down_counter_timer;

    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] out;
    logic       busy, tc, done;

    int checks = 0;
    int errors = 0;

    // model: remaining count, reload value, and which phase the timer is in
    int  m_out = 0;
    int  m_rel = 0;
    bit  m_running = 0;
    bit  m_expired = 0;
    bit  m_tc = 0;

    eight_bit_down_counter_timer #(.WIDTH(8)) dut (
        .Clk(Clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .out(out), .busy(busy), .tc(tc), .done(done)
    );

    always #5 Clk = ~Clk;

    task automatic model_launch(input int v);
        if (v != 0) begin
            m_running = 1;
        end else begin
            m_expired = 1;
            m_tc = 1;
        end
    endtask

    task automatic model_step(input bit ld, input int lv, input bit st, input bit pa);
        m_tc = 0;
        if (m_running) begin
            if (ld) begin
                m_out = lv;
                m_rel = lv;
                if (lv == 0) begin
                    m_running = 0;
                    m_expired = 1;
                    m_tc = 1;
                end
            end else if (!pa) begin
                if (m_out == 0) begin
                    m_out = m_rel;
                    if (m_rel == 0) begin
                        m_running = 0;
                        m_expired = 1;
                    end
                end else begin
                    m_out = m_out - 1;
                    if (m_out == 0) begin
                        m_tc = 1;
`ifndef AUTO_RELOAD_EN
                        m_running = 0;
                        m_expired = 1;
`endif
                    end
                end
            end
        end else if (m_expired) begin
            if (ld) begin
                m_out = lv;
                m_rel = lv;
                m_expired = 0;
                if (st) model_launch(lv);
            end else if (st) begin
                if (m_rel != 0) begin
                    m_out = m_rel;
                    m_expired = 0;
                    m_running = 1;
                end else begin
                    m_tc = 1;
                end
            end
        end else begin
            if (ld) begin
                m_out = lv;
                m_rel = lv;
                if (st) model_launch(lv);
            end else if (st) begin
                model_launch(m_out);
            end
        end
    endtask

    task automatic step(input bit ld, input int lv, input bit st, input bit pa);
        load = ld;
        load_val = lv[7:0];
        start = st;
        pause = pa;
        @(posedge Clk);
        model_step(ld, lv, st, pa);
        #1;
        load = 0;
        start = 0;
        pause = 0;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b0;
        m_out = 0; m_rel = 0; m_running = 0; m_expired = 0; m_tc = 0;
        @(posedge Clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (out !== 8'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: out=%0d busy=%b tc=%b done=%b, want 0 0 0 0", out, busy, tc, done);
        end
        rst = 1'b1;
        step(1, 7, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (out !== 8'd5) begin
            errors++;
            $display("FAIL reset_precount: out=%0d want 5", out);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out !== 8'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%0d busy=%b tc=%b done=%b, want 0 0 0 0", out, busy, tc, done);
        end
        m_out = 0; m_rel = 0; m_running = 0; m_expired = 0; m_tc = 0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out=%0d busy=%b done=%b, want 0 0 0", out, busy, done);
        end
        rst = 1'b1;
    endtask

`ifndef AUTO_RELOAD_EN
    task automatic test_basic_count();
        int exp_out [4] = '{3, 2, 1, 0};
        apply_reset();
        step(1, 3, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== exp_out[i][7:0] || tc !== (i == 3) || busy !== (i != 3) || done !== (i == 3)) begin
                errors++;
                $display("FAIL basic_count[%0d]: out=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                         i, out, tc, busy, done, exp_out[i], i == 3, i != 3, i == 3);
            end
            if (i < 3) step(0, 0, 0, 0);
        end
        step(0, 0, 0, 0);
        checks++;
        if (tc !== 1'b0 || done !== 1'b1 || out !== 8'd0) begin
            errors++;
            $display("FAIL basic_after: tc=%b done=%b out=%0d, want 0 1 0", tc, done, out);
        end
    endtask

    task automatic test_pause();
        int exp_out [7] = '{4, 3, 3, 3, 2, 1, 0};
        bit pa_seq  [7] = '{0, 0, 1, 1, 0, 0, 0};
        apply_reset();
        step(1, 4, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step(0, 0, 0, pa_seq[i]);
            checks++;
            if (out !== exp_out[i][7:0] || tc !== (i == 6)) begin
                errors++;
                $display("FAIL pause[%0d]: out=%0d tc=%b, want %0d %b", i, out, tc, exp_out[i], i == 6);
            end
        end
    endtask

    task automatic test_load_zero_start();
        apply_reset();
        step(1, 0, 1, 0);
        checks++;
        if (done !== 1'b1 || tc !== 1'b1 || busy !== 1'b0 || out !== 8'd0) begin
            errors++;
            $display("FAIL load_zero_start: done=%b tc=%b busy=%b out=%0d, want 1 1 0 0", done, tc, busy, out);
        end
        step(0, 0, 0, 0);
        checks++;
        if (tc !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL load_zero_after: tc=%b done=%b, want 0 1", tc, done);
        end
    endtask

    task automatic test_load_in_run();
        apply_reset();
        step(1, 5, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        checks++;
        if (out !== 8'd2) begin
            errors++;
            $display("FAIL load_run_pre: out=%0d want 2", out);
        end
        step(1, 6, 0, 0);
        for (int v = 6; v >= 0; v--) begin
            checks++;
            if (out !== v[7:0] || tc !== (v == 0) || busy !== (v != 0)) begin
                errors++;
                $display("FAIL load_run[%0d]: out=%0d tc=%b busy=%b", v, out, tc, busy);
            end
            if (v > 0) step(0, 0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(1, 2, 1, 0);
        for (int v = 2; v >= 0; v--) begin
            checks++;
            if (out !== v[7:0] || tc !== (v == 0)) begin
                errors++;
                $display("FAIL load_start[%0d]: out=%0d tc=%b", v, out, tc);
            end
            if (v > 0) step(0, 0, 0, 0);
        end
    endtask

    task automatic test_restart_done();
        int tcs = 0;
        apply_reset();
        step(1, 5, 1, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        checks++;
        if (out !== 8'd5 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart: out=%0d busy=%b done=%b, want 5 1 0", out, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            if (tc === 1'b1) tcs++;
        end
        checks++;
        if (tcs != 1 || out !== 8'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL restart_tc: tc_count=%0d out=%0d done=%b, want 1 0 1", tcs, out, done);
        end
        step(1, 9, 0, 0);
        checks++;
        if (out !== 8'd9 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_load: out=%0d busy=%b done=%b, want 9 0 0", out, busy, done);
        end
    endtask
`else
    task automatic test_auto_reload();
        int exp_out [9] = '{2, 1, 0, 2, 1, 1, 0, 2, 1};
        bit pa_seq  [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        apply_reset();
        step(1, 2, 1, 0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step(0, 0, 0, pa_seq[i]);
            checks++;
            if (out !== exp_out[i][7:0] || tc !== (exp_out[i] == 0) || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL auto_reload[%0d]: out=%0d tc=%b done=%b busy=%b, want %0d", i, out, tc, done, busy, exp_out[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int lv;
        bit ld, st, pa;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            ld = ($urandom_range(0, 99) < 8);
            st = ($urandom_range(0, 99) < 20);
            pa = ($urandom_range(0, 99) < 25);
            lv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            step(ld, lv, st, pa);
            checks++;
            if (out !== m_out[7:0] || busy !== m_running || tc !== m_tc || done !== m_expired) begin
                errors++;
                $display("FAIL random[%0d]: out=%0d busy=%b tc=%b done=%b, want %0d %b %b %b",
                         c, out, busy, tc, done, m_out, m_running, m_tc, m_expired);
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
`ifndef AUTO_RELOAD_EN
        test_basic_count();
        test_pause();
        test_load_zero_start();
        test_load_in_run();
        test_back_to_back();
        test_restart_done();
`else
        test_auto_reload();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
